// File: rtl/bus_slave_mem_if.sv
// rtl/bus_slave_mem_if.sv - bit-serial bus signals between arbiter-side master and memory slave
interface bus_slave_mem_if;
  logic B_UTIL;
  logic B_RW;
  logic B_BUS_OUT;
  logic B_BUS_IN;
  logic B_ACK;
  logic S_BSY;

  modport master (output B_UTIL, B_RW, B_BUS_OUT, input B_BUS_IN, B_ACK, S_BSY);
  modport slave  (input B_UTIL, B_RW, B_BUS_OUT, output B_BUS_IN, B_ACK, S_BSY);
endinterface

// File: rtl/bus_slave_mem.sv
// rtl/bus_slave_mem.sv - parametrised serial-bus memory slave with device-select decode
// Define BUS_SLAVE_BURST_EN to continue at idx+1 while B_UTIL stays high after each word.
module bus_slave_mem #(
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 2048,
  parameter int                DEV_W  = 5,
  parameter logic [DEV_W-1:0]  DEV_ID = '0
) (
  input  logic             CLK,
  input  logic             RSTN,
  bus_slave_mem_if.slave   bus
);
  localparam int MEM_AW  = $clog2(DEPTH);
  localparam int ADDR_W  = DEV_W + MEM_AW;
  localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, ADDR, ACK, WRITE, READ, RELEASE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-2:0] addr_sr;
  logic [DATA_W-1:0] data_sr;
  logic [MEM_AW-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  logic              rw;
  logic              match;
  logic              b_ack;
  logic              b_bus_in;
  logic              s_bsy;

  logic [ADDR_W-1:0] addr_full;
  logic [DATA_W-1:0] wr_word;
  logic              last_addr;
  logic              last_bit;
  logic              mem_we;

  // The final address/data bit is merged straight from the line, so it never sits in a register.
  assign addr_full = {bus.B_BUS_OUT, addr_sr};
  assign wr_word   = {bus.B_BUS_OUT, data_sr[DATA_W-1:1]};
  assign last_addr = (cnt == CNT_W'(ADDR_W - 1));
  assign last_bit  = (cnt == CNT_W'(DATA_W - 1));
  assign mem_we    = (state == WRITE) && bus.B_UTIL && last_bit;

`ifdef BUS_SLAVE_BURST_EN
  logic [MEM_AW-1:0] idx_nxt;
  assign idx_nxt = idx + 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (mem_we)
      mem[idx] <= wr_word;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      addr_sr  <= '0;
      data_sr  <= '0;
      idx      <= '0;
      cnt      <= '0;
      rw       <= 1'b0;
      match    <= 1'b0;
      b_ack    <= 1'b0;
      b_bus_in <= 1'b0;
      s_bsy    <= 1'b0;
    end else begin
      b_ack <= 1'b0;
      if (state != IDLE && state != RELEASE && !bus.B_UTIL) begin
        state    <= IDLE;
        cnt      <= '0;
        b_bus_in <= 1'b0;
        s_bsy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.B_UTIL) begin
              state   <= ADDR;
              rw      <= bus.B_RW;
              addr_sr <= {bus.B_BUS_OUT, addr_sr[ADDR_W-2:1]};
              cnt     <= CNT_W'(1);
              s_bsy   <= 1'b1;
            end
          end
          ADDR: begin
            if (last_addr) begin
              state <= ACK;
              idx   <= addr_full[MEM_AW-1:0];
              match <= (addr_full[ADDR_W-1:MEM_AW] == DEV_ID);
              b_ack <= (addr_full[ADDR_W-1:MEM_AW] == DEV_ID);
              cnt   <= '0;
            end else begin
              addr_sr <= {bus.B_BUS_OUT, addr_sr[ADDR_W-2:1]};
              cnt     <= cnt + 1'b1;
            end
          end
          ACK: begin
            if (!match) begin
              state <= RELEASE;
            end else if (rw) begin
              state <= WRITE;
            end else begin
              state    <= READ;
              b_bus_in <= mem[idx][0];
              data_sr  <= mem[idx] >> 1;
            end
          end
          WRITE: begin
            data_sr <= wr_word;
            if (last_bit) begin
              b_ack <= 1'b1;
              cnt   <= '0;
`ifdef BUS_SLAVE_BURST_EN
              idx   <= idx_nxt;
`else
              state <= RELEASE;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          READ: begin
            if (last_bit) begin
              cnt <= '0;
`ifdef BUS_SLAVE_BURST_EN
              // Prefetch so the next word's bit0 follows without a gap.
              idx      <= idx_nxt;
              b_bus_in <= mem[idx_nxt][0];
              data_sr  <= mem[idx_nxt] >> 1;
`else
              b_bus_in <= 1'b0;
              state    <= RELEASE;
`endif
            end else begin
              b_bus_in <= data_sr[0];
              data_sr  <= data_sr >> 1;
              cnt      <= cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (!bus.B_UTIL) begin
              state <= IDLE;
              s_bsy <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            s_bsy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.B_ACK    = b_ack;
  assign bus.B_BUS_IN = b_bus_in;
  assign bus.S_BSY    = s_bsy;
endmodule
